// File: rtl/uart_tx_block.sv
// uart_tx_block: UART transmitter with a one-entry holding buffer, LSB-first frames,
// one start and one stop bit, and a sticky overrun flag.
module uart_tx_block (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [7:0]  tx_data,
    input  logic        tx_load,
    input  logic [3:0]  data_size,
    input  logic [13:0] bit_period,
    input  logic        err_clear,
    output logic        serial_out,
    output logic        tx_busy,
    output logic        buffer_full,
    output logic        overrun_error
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t      state_q, state_d;
    logic [7:0]  buf_q, buf_d, shift_q, shift_d;
    logic        buf_full_q, buf_full_d;
    logic [3:0]  ds_q, ds_d, eff_ds;
    logic [13:0] bp_q, bp_d, eff_bp, tmr_q, tmr_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic        ovr_q, ovr_d, serial_q, serial_d, busy_q, busy_d;
    logic        bit_end, last_bit, transfer;

    assign eff_ds   = (data_size < 4'd5 || data_size > 4'd8) ? 4'd8 : data_size;
    assign eff_bp   = (bit_period < 14'd2) ? 14'd2 : bit_period;
    assign bit_end  = tmr_q == bp_q;
    assign last_bit = {1'b0, bcnt_q} == ds_q - 4'd1;
    // The buffer feeds the shifter from IDLE, or at the end of a stop bit for back-to-back frames
    assign transfer = buf_full_q && (state_q == IDLE || (state_q == STOP && bit_end));

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        ds_d    = ds_q;
        bp_d    = bp_q;
        tmr_d   = tmr_q + 14'd1;
        bcnt_d  = bcnt_q;
        if (transfer) begin
            state_d = START;
            shift_d = buf_q;
            ds_d    = eff_ds;
            bp_d    = eff_bp;
            tmr_d   = 14'd1;
            bcnt_d  = 3'd0;
        end else if (state_q == IDLE) begin
            tmr_d = 14'd0;
        end else if (bit_end) begin
            tmr_d   = 14'd1;
            state_d = (state_q == START) ? DATA : (state_q == DATA) ? (last_bit ? STOP : DATA) : IDLE;
            shift_d = (state_q == DATA) ? shift_q >> 1 : shift_q;
            bcnt_d  = (state_q == DATA && !last_bit) ? bcnt_q + 3'd1 : 3'd0;
        end
        buf_full_d = tx_load | (buf_full_q & ~transfer);
        buf_d      = (tx_load && (!buf_full_q || transfer)) ? tx_data : buf_q;
        ovr_d      = (tx_load & buf_full_q & ~transfer) | (ovr_q & ~err_clear);
        // Line and busy are registered from the next state so they change exactly on state edges
        serial_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
        busy_d     = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            ds_q       <= '0;
            bp_q       <= '0;
            tmr_q      <= '0;
            bcnt_q     <= '0;
            ovr_q      <= 1'b0;
            serial_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            ds_q       <= ds_d;
            bp_q       <= bp_d;
            tmr_q      <= tmr_d;
            bcnt_q     <= bcnt_d;
            ovr_q      <= ovr_d;
            serial_q   <= serial_d;
            busy_q     <= busy_d;
        end
    end

    assign serial_out    = serial_q;
    assign tx_busy       = busy_q;
    assign buffer_full   = buf_full_q;
    assign overrun_error = ovr_q;
endmodule

// File: tb/tb_uart_tx_block.sv
// tb_uart_tx_block: directed vector table plus hand-written back-to-back, overrun and reset sequences.
module tb_uart_tx_block;
    logic        clk = 1'b0;
    logic        n_rst;
    logic [7:0]  tx_data;
    logic        tx_load;
    logic [3:0]  data_size;
    logic [13:0] bit_period;
    logic        err_clear;
    logic        serial_out, tx_busy, buffer_full, overrun_error;
    int          checks, errors;

    typedef struct {
        logic [7:0]  d;
        logic [3:0]  ds;
        logic [13:0] bp;
        logic [11:0] line;
        int          n;
        int          ebp;
    } vec_t;
    vec_t vecs[6];

    uart_tx_block dut (
        .clk(clk), .n_rst(n_rst), .tx_data(tx_data), .tx_load(tx_load),
        .data_size(data_size), .bit_period(bit_period), .err_clear(err_clear),
        .serial_out(serial_out), .tx_busy(tx_busy), .buffer_full(buffer_full),
        .overrun_error(overrun_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        tx_load   = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    // Called at the cycle-0 sample of a frame; returns at the first sample after the frame.
    task automatic check_frame(input logic [11:0] line, input int n, input int bp,
                               input logic full_mid, input string name);
        for (int i = 0; i < n; i++) begin
            logic       bad;
            logic [2:0] got;
            bad = 1'b0;
            got = 3'b0;
            for (int j = 0; j < bp; j++) begin
                if (!bad && (serial_out !== line[i] || tx_busy !== 1'b1 ||
                             (full_mid && (i + j) > 0 && buffer_full !== 1'b1))) begin
                    bad = 1'b1;
                    got = {serial_out, tx_busy, buffer_full};
                end
                step();
            end
            checks++;
            if (bad) begin
                errors++;
                $display("FAIL %s bit %0d: serial/busy/full=%b, expected serial=%b busy=1",
                         name, i, got, line[i]);
            end
        end
    endtask

    task automatic check_idle(input int cycles, input string name);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < cycles; k++) begin
            if (serial_out !== 1'b1 || tx_busy !== 1'b0) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL %s: line left idle, got serial=%b busy=%b, expected 1/0",
                     name, serial_out, tx_busy);
        end
    endtask

    initial begin
        n_rst = 1'b0; tx_load = 1'b0; tx_data = 8'h00; data_size = 4'd8;
        bit_period = 14'd10; err_clear = 1'b0; checks = 0; errors = 0;
        vecs[0] = '{8'hA5, 4'd8,  14'd10, 12'h34A, 10, 10};
        vecs[1] = '{8'hF3, 4'd5,  14'd16, 12'h066, 7,  16};
        vecs[2] = '{8'h80, 4'd12, 14'd1,  12'h300, 10, 2};
        vecs[3] = '{8'h3C, 4'd7,  14'd3,  12'h178, 9,  3};
        vecs[4] = '{8'h96, 4'd0,  14'd0,  12'h32C, 10, 2};
        vecs[5] = '{8'hFF, 4'd4,  14'd2,  12'h3FE, 10, 2};

        repeat (2) @(posedge clk);
        #1;
        chk("reset serial_out", serial_out, 1'b1);
        chk("reset tx_busy", tx_busy, 1'b0);
        chk("reset buffer_full", buffer_full, 1'b0);
        chk("reset overrun_error", overrun_error, 1'b0);
        n_rst = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            tx_data = vecs[v].d; data_size = vecs[v].ds; bit_period = vecs[v].bp; tx_load = 1'b1;
            step();
            chk($sformatf("vec%0d buffer_full after load", v), buffer_full, 1'b1);
            chk($sformatf("vec%0d line high before start", v), serial_out, 1'b1);
            step();
            data_size = 4'd5; bit_period = 14'd7;
            check_frame(vecs[v].line, vecs[v].n, vecs[v].ebp, 1'b0, $sformatf("vec%0d", v));
            chk($sformatf("vec%0d busy after frame", v), tx_busy, 1'b0);
            chk($sformatf("vec%0d line after frame", v), serial_out, 1'b1);
            chk($sformatf("vec%0d buffer empty after frame", v), buffer_full, 1'b0);
            repeat (3) step();
        end

        data_size = 4'd8; bit_period = 14'd10;
        tx_data = 8'h55; tx_load = 1'b1;
        step();
        step();
        tx_data = 8'h0F; tx_load = 1'b1;
        check_frame(12'h2AA, 10, 10, 1'b1, "b2b first 0x55");
        chk("b2b start without gap", serial_out, 1'b0);
        chk("b2b busy stays high", tx_busy, 1'b1);
        chk("b2b buffer drained", buffer_full, 1'b0);
        check_frame(12'h21E, 10, 10, 1'b0, "b2b second 0x0F");
        check_idle(20, "b2b idle after");

        bit_period = 14'd4;
        tx_data = 8'h11; tx_load = 1'b1;
        step();
        step();
        tx_data = 8'h22; tx_load = 1'b1;
        step();
        chk("ovr 0x22 accepted full", buffer_full, 1'b1);
        chk("ovr none yet", overrun_error, 1'b0);
        tx_data = 8'h33; tx_load = 1'b1;
        step();
        chk("ovr set on 0x33", overrun_error, 1'b1);
        err_clear = 1'b1;
        step();
        chk("ovr cleared", overrun_error, 1'b0);
        tx_data = 8'h44; tx_load = 1'b1; err_clear = 1'b1;
        step();
        chk("ovr set wins over clear", overrun_error, 1'b1);
        for (int k = 0; k < 200 && buffer_full; k++) step();
        chk("ovr buffer transfer", buffer_full, 1'b0);
        check_frame(12'h244, 10, 4, 1'b0, "ovr frame 0x22");
        check_idle(60, "ovr dropped bytes never sent");
        err_clear = 1'b1;
        step();
        chk("ovr final clear", overrun_error, 1'b0);

        bit_period = 14'd10;
        tx_data = 8'h00; tx_load = 1'b1;
        step();
        step();
        tx_data = 8'h5A; tx_load = 1'b1;
        step();
        tx_data = 8'h77; tx_load = 1'b1;
        step();
        repeat (31) step();
        chk("rst pre: line low in d2", serial_out, 1'b0);
        chk("rst pre: overrun set", overrun_error, 1'b1);
        chk("rst pre: buffer full", buffer_full, 1'b1);
        n_rst = 1'b0;
        #1;
        chk("rst async serial_out", serial_out, 1'b1);
        chk("rst async tx_busy", tx_busy, 1'b0);
        chk("rst async buffer_full", buffer_full, 1'b0);
        chk("rst async overrun_error", overrun_error, 1'b0);
        repeat (2) step();
        n_rst = 1'b1;
        check_idle(60, "rst no resume");
        chk("rst buffer stays empty", buffer_full, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
